// File: rtl/droute_pkg.sv
// Shared widths and types for the data_route 128 <-> 1536 bit AXI4-Stream width converters.
package droute_pkg;

  localparam int DROUTE_WIDE_W   = 1536;
  localparam int DROUTE_NARROW_W = 128;
  localparam int DROUTE_RATIO    = DROUTE_WIDE_W / DROUTE_NARROW_W;

  typedef logic [3:0] droute_slice_t;

endpackage

// File: rtl/axis_frame_cnt.sv
// Frame beat counter with frame_len latch and combinational tlast compare.
// Length is sampled on the first beat of each frame, so mid-frame frame_len changes are ignored.
module axis_frame_cnt #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beat,
  input  logic [LEN_W-1:0] frame_len,
  output logic             last
);

  logic [LEN_W-1:0] beat_q;
  logic [LEN_W-1:0] frame_len_q;
  logic [LEN_W-1:0] len_eff;

  // Before the first beat of a frame the latch is stale, so compare against the live input.
  assign len_eff = (beat_q == '0) ? frame_len : frame_len_q;
  assign last    = (len_eff != '0) && (beat_q == (len_eff - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q      <= '0;
      frame_len_q <= '0;
    end else if (beat) begin
      if (beat_q == '0) begin
        frame_len_q <= frame_len;
      end
      beat_q <= last ? '0 : beat_q + LEN_W'(1);
    end
  end

endmodule

// File: rtl/axis_down1536_to128.sv
// 1536->128 AXIS downsizer: 12 LSB-first slices per word, first slice 1 cycle after accept, 1 beat/clk sustained.
// Input stalls while a word is draining; framing (frame_len/tlast) only when AXIS_DOWN_FRAME_EN is defined.
module axis_down1536_to128
  import droute_pkg::*;
#(
  parameter int IN_W  = DROUTE_WIDE_W,
  parameter int OUT_W = DROUTE_NARROW_W,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LEN_W-1:0]   frame_len,
  input  logic [IN_W-1:0]    s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [OUT_W-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [OUT_W/8-1:0] m_axis_tkeep,
  output logic               m_axis_tlast
);

  localparam int            RATIO    = IN_W / OUT_W;
  localparam droute_slice_t LAST_IDX = droute_slice_t'(RATIO - 1);

  logic [RATIO-1:0][OUT_W-1:0] hold_q;
  logic                        full_q;
  droute_slice_t               idx_q;

  logic fire;
  logic word_done;
  logic accept;
  logic last;

  assign fire          = full_q & m_axis_tready;
  // A frame ending mid-word retires the word early; the remaining slices are dropped.
  assign word_done     = fire & ((idx_q == LAST_IDX) | last);
  assign s_axis_tready = ~full_q | word_done;
  assign accept        = s_axis_tvalid & s_axis_tready;

  assign m_axis_tvalid = full_q;
  assign m_axis_tdata  = hold_q[idx_q];
  assign m_axis_tkeep  = '1;
  assign m_axis_tlast  = full_q & last;

`ifdef AXIS_DOWN_FRAME_EN
  axis_frame_cnt #(
    .LEN_W(LEN_W)
  ) u_frame_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .beat     (fire),
    .frame_len(frame_len),
    .last     (last)
  );
`else
  logic frame_len_unused;
  assign frame_len_unused = ^frame_len;
  assign last             = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      idx_q  <= '0;
    end else if (accept) begin
      full_q <= 1'b1;
      idx_q  <= '0;
    end else if (word_done) begin
      full_q <= 1'b0;
      idx_q  <= '0;
    end else if (fire) begin
      idx_q <= idx_q + droute_slice_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_q <= s_axis_tdata;
    end
  end

endmodule

// File: tb/tb_axis_down1536_to128.sv
// Self-checking bench for axis_down1536_to128; expectations follow AXIS_DOWN_FRAME_EN when defined.
module tb_axis_down1536_to128;

`ifdef AXIS_DOWN_FRAME_EN
  localparam bit FRAMED = 1'b1;
`else
  localparam bit FRAMED = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [15:0]   frame_len;
  logic [1535:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [127:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [15:0]   m_axis_tkeep;
  logic          m_axis_tlast;

  axis_down1536_to128 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_len    (frame_len),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] d;
    logic         l;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [15:0] mbeat  = '0;

  function automatic logic [1535:0] ramp_word();
    logic [1535:0] w;
    logic [3:0]    nib;
    for (int k = 0; k < 12; k++) begin
      nib = 4'(k);
      w[k*128 +: 128] = {32{nib}};
    end
    return w;
  endfunction

  function automatic logic [1535:0] rand_word();
    logic [1535:0] w;
    for (int i = 0; i < 48; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Reference model: expected beats of one accepted word, with frame position in mbeat.
  task automatic model_word(input logic [1535:0] w);
    logic l;
    for (int k = 0; k < 12; k++) begin
      l = 1'b0;
      if (FRAMED && frame_len != 16'd0 && mbeat == frame_len - 16'd1) l = 1'b1;
      exp_q.push_back('{d: w[k*128 +: 128], l: l});
      if (l) begin
        mbeat = 16'd0;
        break;
      end
      mbeat = mbeat + 16'd1;
    end
  endtask

  // One clock: drive inputs at negedge, sample 1 ns later (values seen at the next posedge).
  task automatic step(input logic sv, input logic [1535:0] sd, input logic mr,
                      output logic acc, output logic fire, output logic ov,
                      output logic [127:0] od, output logic ol);
    @(negedge clk);
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    m_axis_tready = mr;
    #1;
    cyc++;
    acc  = sv & s_axis_tready;
    ov   = m_axis_tvalid;
    fire = m_axis_tvalid & mr;
    od   = m_axis_tdata;
    ol   = m_axis_tlast;
    if (acc) model_word(sd);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    mbeat = '0;
  endtask

  task automatic test_reset();
    frame_len = 16'd1;
    do_reset();
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
    checks++; if (m_axis_tkeep !== 16'hffff) begin errors++; $display("FAIL reset_tkeep got=%h exp=ffff", m_axis_tkeep); end
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got=%b exp=1", s_axis_tready); end
  endtask

  task automatic test_ramp();
    logic acc, fire, ov, ol;
    logic [127:0] od;
    logic [1535:0] w;
    beat_t e;
    int wi = 0, nb = 0, acc_c = -1, first_c = -1;
    w = ramp_word();
    frame_len = 16'd0;
    do_reset();
    for (int c = 0; c < 100 && (wi < 1 || exp_q.size() != 0); c++) begin
      step(wi < 1, w, 1'b1, acc, fire, ov, od, ol);
      if (acc) begin acc_c = cyc; wi++; end
      if (fire) begin
        if (first_c < 0) first_c = cyc;
        nb++;
        checks++; if (m_axis_tkeep !== 16'hffff) begin errors++; $display("FAIL ramp_tkeep got=%h exp=ffff", m_axis_tkeep); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ramp_extra got data=%h exp no beat", od); end
        else begin
          e = exp_q.pop_front();
          if (od !== e.d || ol !== e.l) begin errors++; $display("FAIL ramp_beat got=%h/%b exp=%h/%b", od, ol, e.d, e.l); end
        end
      end
    end
    checks++; if (first_c != acc_c + 1) begin errors++; $display("FAIL ramp_latency got=%0d exp=%0d", first_c - acc_c, 1); end
    checks++; if (nb != 12 || exp_q.size() != 0) begin errors++; $display("FAIL ramp_count got=%0d exp=12", nb); end
  endtask

  task automatic test_back_to_back();
    logic acc, fire, ov, ol;
    logic [127:0] od;
    logic [1535:0] w[3];
    beat_t e;
    int wi = 0, nb = 0, bubbles = 0, acc_c[3];
    for (int i = 0; i < 3; i++) w[i] = rand_word();
    frame_len = 16'd0;
    do_reset();
    for (int c = 0; c < 200 && (wi < 3 || exp_q.size() != 0); c++) begin
      step(wi < 3, w[wi % 3], 1'b1, acc, fire, ov, od, ol);
      if (acc) begin acc_c[wi] = cyc; wi++; end
      if (nb > 0 && !fire) bubbles++;
      if (fire) begin
        nb++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra got data=%h exp no beat", od); end
        else begin
          e = exp_q.pop_front();
          if (od !== e.d || ol !== e.l) begin errors++; $display("FAIL b2b_beat got=%h/%b exp=%h/%b", od, ol, e.d, e.l); end
        end
      end
    end
    checks++; if (wi != 3) begin errors++; $display("FAIL b2b_timeout got words=%0d exp=3", wi); end
    for (int i = 1; i < wi; i++) begin
      checks++; if (acc_c[i] - acc_c[0] != 12 * i) begin errors++; $display("FAIL b2b_accept_cycle got=%0d exp=%0d", acc_c[i] - acc_c[0], 12 * i); end
    end
    checks++; if (nb != 36 || bubbles != 0) begin errors++; $display("FAIL b2b_stream got beats=%0d bubbles=%0d exp 36/0", nb, bubbles); end
  endtask

  task automatic test_backpressure();
    logic acc, fire, ov, ol, pv, pf, pl;
    logic [127:0] od, pd;
    logic [1535:0] w[4];
    beat_t e;
    int wi = 0, nb = 0, stalls = 0;
    for (int i = 0; i < 4; i++) w[i] = rand_word();
    frame_len = 16'd10;
    do_reset();
    pv = 1'b0; pf = 1'b0; pd = '0; pl = 1'b0;
    for (int c = 0; c < 800 && (wi < 4 || exp_q.size() != 0); c++) begin
      step(wi < 4, w[wi % 4], 1'($urandom_range(1)), acc, fire, ov, od, ol);
      if (acc) wi++;
      if (pv && !pf) begin
        stalls++;
        checks++;
        if (!ov || od !== pd || ol !== pl) begin errors++; $display("FAIL bp_stable got=%b/%h/%b exp=1/%h/%b", ov, od, ol, pd, pl); end
      end
      if (fire) begin
        nb++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra got data=%h exp no beat", od); end
        else begin
          e = exp_q.pop_front();
          if (od !== e.d || ol !== e.l) begin errors++; $display("FAIL bp_beat got=%h/%b exp=%h/%b", od, ol, e.d, e.l); end
        end
      end
      pv = ov; pf = fire; pd = od; pl = ol;
    end
    checks++; if (wi != 4 || exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout got words=%0d left=%0d exp 4/0", wi, exp_q.size()); end
    checks++; if (nb != (FRAMED ? 40 : 48) || stalls == 0) begin errors++; $display("FAIL bp_count got beats=%0d stalls=%0d exp %0d", nb, stalls, FRAMED ? 40 : 48); end
  endtask

  task automatic test_frame_boundary();
    logic acc, fire, ov, ol;
    logic [127:0] od;
    logic [1535:0] w[2];
    beat_t e;
    int wi = 0, nb = 0, nlast = 0, last_at = -1;
    for (int i = 0; i < 2; i++) w[i] = rand_word();
    frame_len = 16'd24;
    do_reset();
    for (int c = 0; c < 200 && (wi < 2 || exp_q.size() != 0); c++) begin
      step(wi < 2, w[wi % 2], 1'b1, acc, fire, ov, od, ol);
      if (acc) wi++;
      if (fire) begin
        if (ol) begin nlast++; last_at = nb; end
        nb++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL frame_extra got data=%h exp no beat", od); end
        else begin
          e = exp_q.pop_front();
          if (od !== e.d || ol !== e.l) begin errors++; $display("FAIL frame_beat got=%h/%b exp=%h/%b", od, ol, e.d, e.l); end
        end
      end
    end
    checks++; if (nb != 24) begin errors++; $display("FAIL frame_count got=%0d exp=24", nb); end
    checks++;
    if (nlast != (FRAMED ? 1 : 0) || (FRAMED && last_at != 23)) begin
      errors++; $display("FAIL frame_tlast got n=%0d at=%0d exp n=%0d at=23", nlast, last_at, FRAMED ? 1 : 0);
    end
  endtask

  task automatic test_mid_word();
    logic acc, fire, ov, ol;
    logic [127:0] od;
    logic [1535:0] w[2];
    beat_t e;
    int wi = 0, nb = 0;
    w[0] = ramp_word();
    w[1] = rand_word();
    frame_len = 16'd5;
    do_reset();
    for (int c = 0; c < 200 && (wi < 2 || exp_q.size() != 0); c++) begin
      step(wi < 2, w[wi % 2], 1'b1, acc, fire, ov, od, ol);
      if (acc) wi++;
      if (fire) begin
        nb++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL midword_extra got data=%h exp no beat", od); end
        else begin
          e = exp_q.pop_front();
          if (od !== e.d || ol !== e.l) begin errors++; $display("FAIL midword_beat got=%h/%b exp=%h/%b", od, ol, e.d, e.l); end
        end
      end
    end
    checks++; if (nb != (FRAMED ? 10 : 24)) begin errors++; $display("FAIL midword_count got=%0d exp=%0d", nb, FRAMED ? 10 : 24); end
  endtask

  task automatic test_reset_mid();
    logic acc, fire, ov, ol;
    logic [127:0] od;
    logic [1535:0] wa, wb;
    beat_t e;
    int wi = 0, nb = 0;
    wa = rand_word();
    wb = ramp_word();
    frame_len = 16'd7;
    do_reset();
    for (int c = 0; c < 100 && nb < 4; c++) begin
      step(wi < 1, wa, 1'b1, acc, fire, ov, od, ol);
      if (acc) wi++;
      if (fire) nb++;
    end
    checks++; if (nb != 4) begin errors++; $display("FAIL rstmid_prefix got=%0d exp=4", nb); end
    @(negedge clk);
    rst_n = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got=%b exp=0", m_axis_tvalid); end
    rst_n = 1'b1;
    exp_q.delete();
    mbeat = '0;
    wi = 0; nb = 0;
    for (int c = 0; c < 100 && (wi < 1 || exp_q.size() != 0); c++) begin
      step(wi < 1, wb, 1'b1, acc, fire, ov, od, ol);
      if (acc) wi++;
      if (fire) begin
        nb++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rstmid_extra got data=%h exp no beat", od); end
        else begin
          e = exp_q.pop_front();
          if (od !== e.d || ol !== e.l) begin errors++; $display("FAIL rstmid_beat got=%h/%b exp=%h/%b", od, ol, e.d, e.l); end
        end
      end
    end
    checks++; if (nb != (FRAMED ? 7 : 12)) begin errors++; $display("FAIL rstmid_count got=%0d exp=%0d", nb, FRAMED ? 7 : 12); end
  endtask

  initial begin
    rst_n         = 1'b0;
    frame_len     = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    test_reset();
    test_ramp();
    test_back_to_back();
    test_backpressure();
    test_frame_boundary();
    test_mid_word();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
